lsu_pe: RTL
===========

Name: lsu_pe

Overview:
- Per-PE load/store unit of the CGRA; sits directly upstream of the PE ALU.
- Accepts load/store commands from the PE's decoded opcode and runs a single-outstanding req/gnt/rvalid transaction on the PE data-memory port.
- Returns load data plus a one-cycle valid strobe, consumed by the ALU as its load-data / data-request-valid inputs.
- Drives a stall flag so the PE holds its context while a transaction is in flight.

Parameters:
- DWIDTH, 32, data and address width in bits; word size is 4 bytes.

Ports:
- Clk  in  1  clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Exec_En_Global  in  1  global execute enable; commands are accepted only when high.
- LSU_En  in  1  PE slot enable for this unit.
- Opcode  in  5  PE opcode: 5'b00111 = load, 5'b01000 = store; all other values are ignored.
- Addr_In  in  DWIDTH  byte address, signed operand treated as unsigned.
- Store_Data_In  in  DWIDTH  store data.
- data_req_o  out  1  memory request.
- data_addr_o  out  DWIDTH  word-aligned request address.
- data_we_o  out  1  1 = store, 0 = load.
- data_be_o  out  4  byte enables.
- data_wdata_o  out  DWIDTH  store data to memory.
- data_gnt_i  in  1  request granted.
- data_rvalid_i  in  1  response valid (loads and stores).
- data_rdata_i  in  DWIDTH  load response data.
- load_data_o  out  DWIDTH  registered load result, to the ALU.
- data_req_valid_o  out  1  one-cycle strobe: load_data_o is fresh, to the ALU.
- Stall_o  out  1  a transaction is in flight; the PE must hold.
- Misalign_o  out  1  one-cycle strobe: an accepted command had Addr_In[1:0] != 0.

Behaviour:
- Reset (synchronous, high), all registered outputs and state:
  - state = IDLE.
  - data_req_o = 0, data_we_o = 0, data_be_o = 0.
  - data_addr_o = 0, data_wdata_o = 0.
  - load_data_o = 0, data_req_valid_o = 0, Misalign_o = 0.
  - Stall_o = 0.
- Reset takes priority over every other event. Reset mid-transaction drops data_req_o in the next cycle and ignores any later gnt/rvalid.
- State machine: IDLE, REQ, WAIT.
- IDLE:
  - A command is accepted when Exec_En_Global & LSU_En & (Opcode==00111 | Opcode==01000).
  - On accept, latch data_addr_o = {Addr_In[DWIDTH-1:2], 2'b00}, data_we_o = (Opcode==01000), data_wdata_o = Store_Data_In, data_be_o = 4'b1111.
  - On accept, set data_req_o = 1 and go to REQ.
  - Misalign_o pulses in the same update if Addr_In[1:0] != 0. The access still proceeds at the aligned address.
- REQ:
  - data_req_o, data_addr_o, data_we_o, data_wdata_o and data_be_o stay stable until data_gnt_i is seen.
  - On data_gnt_i: clear data_req_o and go to WAIT.
  - data_rvalid_i is ignored in REQ; the memory returns rvalid no earlier than the cycle after gnt.
- WAIT:
  - On data_rvalid_i: go to IDLE and clear data_be_o.
  - For a load, also register load_data_o <= data_rdata_i and set data_req_valid_o = 1 for exactly one cycle.
  - For a store, data_req_valid_o stays 0.
- Stall_o is combinational: (state==REQ) | (state==WAIT).
- load_data_o holds its last value until the next load completes.
- No new command is accepted outside IDLE; Opcode/Addr_In changes during REQ/WAIT have no effect.
- Back-to-back: a new command can be accepted in the same cycle the unit returns to IDLE, i.e. the cycle data_req_valid_o is high.
- Exec_En_Global or LSU_En falling mid-transaction does not abort it; the transaction completes normally.
- Minimum load latency, with accept at cycle N:
  - data_req_o high at N+1; gnt at N+1.
  - rvalid at N+2.
  - load_data_o and data_req_valid_o valid at N+3.
- Gnt wait and rvalid wait are unbounded; there is no timeout.
- Single outstanding transaction only.

Test Plan:
- Load, zero wait: Addr_In=0x100, Opcode=00111, gnt immediately, rvalid with rdata=0xDEADBEEF one cycle later -> data_addr_o=0x100, we=0, be=1111; load_data_o=0xDEADBEEF with data_req_valid_o high exactly one cycle at N+3; Stall_o high at N+1..N+2 only.
- Store with gnt delayed 3 cycles: Addr_In=0x204, Store_Data_In=0x12345678 -> req/addr/wdata stable for 4 cycles, we=1; on rvalid, Stall_o drops, data_req_valid_o stays 0, load_data_o unchanged.
- Misaligned load at Addr_In=0x107 -> Misalign_o one-cycle pulse; data_addr_o=0x104; transaction completes normally.
- Gating: Exec_En_Global=0 with a load opcode, and LSU_En=1 with Opcode=00001 -> no req and no stall. Exec_En_Global dropped during WAIT -> load still completes with a strobe.
- Back-to-back: second load (0x300) presented in the data_req_valid_o cycle of the first -> accepted immediately, req for 0x300 the next cycle.
- Reset asserted in REQ and in WAIT -> next cycle data_req_o=0, Stall_o=0, state IDLE; a later stray rvalid produces no strobe.

Source files
------------

// File: rtl/lsu_pe.sv
// Per-PE load/store unit: turns decoded load/store opcodes into a single-outstanding
// req/gnt/rvalid transaction and hands load data to the ALU with a one-cycle strobe.
module lsu_pe #(
  parameter int DWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Exec_En_Global,
  input  logic              LSU_En,
  input  logic [4:0]        Opcode,
  input  logic [DWIDTH-1:0] Addr_In,
  input  logic [DWIDTH-1:0] Store_Data_In,
  output logic              data_req_o,
  output logic [DWIDTH-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [DWIDTH-1:0] data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [DWIDTH-1:0] data_rdata_i,
  output logic [DWIDTH-1:0] load_data_o,
  output logic              data_req_valid_o,
  output logic              Stall_o,
  output logic              Misalign_o
);

  localparam logic [4:0] OP_LOAD  = 5'b00111;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_req;
  logic                r_we;
  logic [3:0]          r_be;
  logic [DWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [DWIDTH-1:0]   r_load_data;
  logic                r_load_valid;
  logic                r_misalign;

  logic                w_is_mem_op;
  logic                w_accept;
  logic                w_misaligned;

  assign w_is_mem_op  = (Opcode == OP_LOAD) || (Opcode == OP_STORE);
  assign w_accept     = (r_state == ST_IDLE) && Exec_En_Global && LSU_En && w_is_mem_op;
  assign w_misaligned = |Addr_In[1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= 4'b0000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      // Strobes default low so they last exactly one cycle.
      r_load_valid <= 1'b0;
      r_misalign   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr     <= {Addr_In[DWIDTH-1:2], 2'b00};
            r_we       <= (Opcode == OP_STORE);
            r_wdata    <= Store_Data_In;
            r_be       <= 4'b1111;
            r_req      <= 1'b1;
            r_misalign <= w_misaligned;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Request fields stay frozen until the memory grants.
          if (data_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (data_rvalid_i) begin
            r_be    <= 4'b0000;
            r_state <= ST_IDLE;
            if (!r_we) begin
              r_load_data  <= data_rdata_i;
              r_load_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_req_o       = r_req;
  assign data_addr_o      = r_addr;
  assign data_we_o        = r_we;
  assign data_be_o        = r_be;
  assign data_wdata_o     = r_wdata;
  assign load_data_o      = r_load_data;
  assign data_req_valid_o = r_load_valid;
  assign Misalign_o       = r_misalign;
  assign Stall_o          = (r_state == ST_REQ) || (r_state == ST_WAIT);

endmodule
